// File: rtl/self_test_collector.sv
// ---------------------------------------------------------------------------
// self_test_collector
//   Collects self-test frames that chained chips (layers) report after a
//   start pulse. Each accepted frame records a chip's power code in a
//   16-entry table; collection ends on an idle timeout or when chip 15 is
//   recorded.
//
// Ports
//   div_8_clk   in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle pulse, (re)starts a collection from any state
//   frame_valid in   data_in carries a frame this cycle
//   data_in     in   {tag 4'hA, power, chip_id, next_id, 16'hBEEF}
//   rd_addr     in   table read address (chip_id)
//   busy        out  collecting
//   done        out  collection finished, results held
//   layer_count out  distinct chips recorded
//   seq_err     out  sticky: well-formed frame arrived out of order
//   bad_cnt     out  saturating count of malformed frames
//   pwr_sat     out  sticky: a recorded power code was 4'hF
//   rd_power    out  registered table[rd_addr] power
//   rd_present  out  registered table[rd_addr] present bit
// ---------------------------------------------------------------------------
module self_test_collector #(
    parameter int IDLE_TIMEOUT = 63
) (
    input  logic        div_8_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        frame_valid,
    input  logic [31:0] data_in,
    input  logic [3:0]  rd_addr,
    output logic        busy,
    output logic        done,
    output logic [4:0]  layer_count,
    output logic        seq_err,
    output logic [7:0]  bad_cnt,
    output logic        pwr_sat,
    output logic [3:0]  rd_power,
    output logic        rd_present
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [7:0] TIMEOUT = 8'(IDLE_TIMEOUT);

    logic [1:0]  state;
    logic [3:0]  power_tbl [16];
    logic [15:0] present;
    logic [3:0]  expected_id;
    logic [7:0]  timer;

    logic [3:0]  tag, power, chip_id, next_id;
    logic [15:0] marker;
    assign {tag, power, chip_id, next_id, marker} = data_in;

    logic well_formed, active, is_new, is_retx, malformed, tbl_we;
    logic timer_inc, timeout, full;

    assign well_formed = frame_valid && tag == 4'hA && marker == 16'hBEEF &&
                         chip_id != 4'd0 && next_id == chip_id + 4'd1;
    // start wins over any frame in the same cycle
    assign active      = state == S_COLLECT && !start;
    assign is_new      = active && well_formed && chip_id == expected_id;
    assign is_retx     = active && well_formed && chip_id == expected_id - 4'd1;
    assign malformed   = active && frame_valid && !well_formed;
    assign tbl_we      = is_new || is_retx;
    // Malformed frames freeze the timer; silence and out-of-order frames age it.
    assign timer_inc   = active && !tbl_we && !malformed;
    assign timeout     = timer_inc && (timer + 8'd1) == TIMEOUT;
    assign full        = is_new && chip_id == 4'hF;

    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) state <= S_COLLECT;
                S_COLLECT: if (start) state <= S_COLLECT;
                           else if (full || timeout) state <= S_DONE;
                S_DONE:    if (start) state <= S_COLLECT;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) power_tbl[i] <= 4'd0;
            present     <= '0;
            expected_id <= 4'd1;
            timer       <= '0;
            layer_count <= '0;
            seq_err     <= 1'b0;
            bad_cnt     <= '0;
            pwr_sat     <= 1'b0;
            rd_power    <= '0;
            rd_present  <= 1'b0;
        end else begin
            // Sampled before this cycle's write lands: read-before-write.
            rd_power   <= power_tbl[rd_addr];
            rd_present <= present[rd_addr];

            if (start) begin
                present     <= '0;
                expected_id <= 4'd1;
                timer       <= '0;
                layer_count <= '0;
                seq_err     <= 1'b0;
                bad_cnt     <= '0;
                pwr_sat     <= 1'b0;
            end else if (state == S_COLLECT) begin
                if (tbl_we) begin
                    power_tbl[chip_id] <= power;
                    timer              <= '0;
                    if (power == 4'hF) pwr_sat <= 1'b1;
                end else if (timer_inc) begin
                    timer <= timer + 8'd1;
                end
                if (is_new) begin
                    present[chip_id] <= 1'b1;
                    layer_count      <= layer_count + 5'd1;
                    expected_id      <= expected_id + 4'd1;
                end
                if (active && well_formed && !tbl_we) seq_err <= 1'b1;
                if (malformed && bad_cnt != 8'hFF) bad_cnt <= bad_cnt + 8'd1;
            end
        end
    end

    assign busy = state == S_COLLECT;
    assign done = state == S_DONE;

endmodule

// File: tb/tb_self_test_collector.sv
// ---------------------------------------------------------------------------
// tb_self_test_collector
//   Stimulus drives one cycle at a time and pushes the model's expected
//   post-edge outputs into a queue; a monitor pops and compares every cycle.
// ---------------------------------------------------------------------------
module tb_self_test_collector;

    localparam int TO = 20;

    logic        div_8_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        frame_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  rd_addr = '0;
    logic        busy, done, seq_err, pwr_sat, rd_present;
    logic [4:0]  layer_count;
    logic [7:0]  bad_cnt;
    logic [3:0]  rd_power;

    self_test_collector #(.IDLE_TIMEOUT(TO)) dut (
        .div_8_clk(div_8_clk), .rst_n(rst_n), .start(start),
        .frame_valid(frame_valid), .data_in(data_in), .rd_addr(rd_addr),
        .busy(busy), .done(done), .layer_count(layer_count), .seq_err(seq_err),
        .bad_cnt(bad_cnt), .pwr_sat(pwr_sat), .rd_power(rd_power),
        .rd_present(rd_present)
    );

    always #5 div_8_clk = ~div_8_clk;

    typedef struct {
        int busy, done, lc, seq, bad, sat, rp, rpres;
    } exp_t;

    exp_t expq[$];
    int total = 0;
    int bad = 0;

    // ---------------- reference model ----------------
    int m_mode;            // 0 idle, 1 collecting, 2 done
    int m_pwr[16];
    int m_pres[16];
    int m_lc, m_bad, m_timer, m_exp, m_seq, m_sat, m_rp, m_rpres;

    task automatic model_reset();
        m_mode = 0; m_lc = 0; m_bad = 0; m_timer = 0; m_exp = 1;
        m_seq = 0; m_sat = 0; m_rp = 0; m_rpres = 0;
        for (int i = 0; i < 16; i++) begin m_pwr[i] = 0; m_pres[i] = 0; end
    endtask

    task automatic model_step(input bit r, input bit s, input bit fv,
                              input logic [31:0] d, input int ra);
        int tg, p, id, nid, mk;
        bit wf, acc;
        if (!r) begin model_reset(); return; end
        m_rp = m_pwr[ra];
        m_rpres = m_pres[ra];
        if (s) begin
            m_mode = 1; m_lc = 0; m_bad = 0; m_timer = 0; m_exp = 1;
            m_seq = 0; m_sat = 0;
            for (int i = 0; i < 16; i++) m_pres[i] = 0;
        end else if (m_mode == 1) begin
            tg = int'(d[31:28]); p = int'(d[27:24]); id = int'(d[23:20]);
            nid = int'(d[19:16]); mk = int'(d[15:0]);
            wf = fv && tg == 10 && mk == 'hBEEF && id != 0 && nid == (id + 1) % 16;
            acc = 0;
            if (fv && !wf) begin
                if (m_bad < 255) m_bad++;
            end else if (wf && id == m_exp) begin
                acc = 1;
                m_pwr[id] = p; m_pres[id] = 1; m_lc++; m_exp = (m_exp + 1) % 16;
                if (p == 15) m_sat = 1;
                if (m_lc == 15) m_mode = 2;
            end else if (wf && id == (m_exp + 15) % 16) begin
                acc = 1;
                m_pwr[id] = p;
                if (p == 15) m_sat = 1;
            end else if (wf) begin
                m_seq = 1;
            end
            if (acc) m_timer = 0;
            else if (!fv || wf) begin
                m_timer++;
                if (m_timer == TO) m_mode = 2;
            end
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.busy = (m_mode == 1); e.done = (m_mode == 2); e.lc = m_lc;
        e.seq = m_seq; e.bad = m_bad; e.sat = m_sat; e.rp = m_rp; e.rpres = m_rpres;
        return e;
    endfunction

    function automatic logic [31:0] mkf(input int p, input int id, input int nid);
        return {4'hA, 4'(p), 4'(id), 4'(nid), 16'hBEEF};
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge div_8_clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("busy", int'(busy), e.busy);
            chk("done", int'(done), e.done);
            chk("layer_count", int'(layer_count), e.lc);
            chk("seq_err", int'(seq_err), e.seq);
            chk("bad_cnt", int'(bad_cnt), e.bad);
            chk("pwr_sat", int'(pwr_sat), e.sat);
            chk("rd_power", int'(rd_power), e.rp);
            chk("rd_present", int'(rd_present), e.rpres);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input bit s, input bit fv,
                       input logic [31:0] d, input int ra);
        @(negedge div_8_clk);
        #1;
        rst_n = r; start = s; frame_valid = fv; data_in = d; rd_addr = 4'(ra);
        if (!r) begin
            // reset must act without waiting for a clock edge
            #1;
            chk("rst_imm_busy", int'(busy), 0);
            chk("rst_imm_done", int'(done), 0);
            chk("rst_imm_lc", int'(layer_count), 0);
            chk("rst_imm_bad", int'(bad_cnt), 0);
            chk("rst_imm_rp", int'(rd_power), 0);
        end
        model_step(r, s, fv, d, ra);
        @(posedge div_8_clk);
        #1;
        expq.push_back(snap());
    endtask

    task automatic idle(input int n, input int ra);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 32'h0, ra);
    endtask

    initial begin
        model_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // frames in IDLE are ignored
        cyc(1, 0, 1, mkf(3, 1, 2), 1);
        idle(2, 1);

        // three layers then silence until timeout
        cyc(1, 1, 0, 0, 2);
        cyc(1, 0, 1, 32'hA312BEEF, 2);
        cyc(1, 0, 1, 32'hA523BEEF, 2);
        cyc(1, 0, 1, 32'hA734BEEF, 2);
        idle(TO + 4, 2);

        // retransmit overwrites power only
        cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 1, mkf(3, 1, 2), 1);
        cyc(1, 0, 1, mkf(4, 1, 2), 1);
        idle(3, 1);

        // out-of-order id
        cyc(1, 1, 0, 0, 3);
        cyc(1, 0, 1, mkf(1, 1, 2), 3);
        cyc(1, 0, 1, 32'hA234BEEF, 3);
        idle(3, 3);

        // malformed frames, then saturation
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 32'h5312BEEF, 0);
        cyc(1, 0, 1, 32'hA312DEAD, 0);
        cyc(1, 0, 1, 32'hA315BEEF, 0);
        cyc(1, 0, 1, 32'hA301BEEF, 0);
        idle(2, 0);
        for (int i = 0; i < 300; i++) cyc(1, 0, 1, 32'hA312DEAD, 0);
        idle(2, 0);

        // start colliding with a frame: start wins
        cyc(1, 0, 1, mkf(2, 1, 2), 1);
        cyc(1, 1, 1, mkf(6, 2, 3), 2);
        idle(2, 2);

        // full chain, id 15 at power F
        cyc(1, 1, 0, 0, 15);
        for (int id = 1; id <= 15; id++)
            cyc(1, 0, 1, mkf(id == 15 ? 15 : id % 15, id, (id + 1) % 16), 15);
        cyc(1, 0, 1, mkf(2, 1, 2), 15);   // ignored in DONE
        idle(2, 15);
        // new run, reset mid-collection
        cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 1, mkf(9, 1, 2), 1);
        cyc(1, 0, 1, mkf(9, 2, 3), 1);
        cyc(0, 0, 1, mkf(9, 3, 4), 1);
        idle(3, 1);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit r, s, fv;
            int kind, id;
            logic [31:0] d;
            r = $urandom_range(0, 299) != 0;
            s = $urandom_range(0, 59) == 0;
            fv = $urandom_range(0, 2) != 0;
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                case ($urandom_range(0, 5))
                    0: id = (m_exp + 15) % 16;
                    1: id = (m_exp + 2) % 16;
                    default: id = m_exp;
                endcase
                d = mkf($urandom_range(0, 15), id, (id + 1) % 16);
            end else if (kind < 8) begin
                d = $urandom;
            end else begin
                id = $urandom_range(0, 15);
                d = mkf($urandom_range(0, 15), id, (id + 1) % 16);
            end
            cyc(r, s, fv, d, $urandom_range(0, 15));
        end

        @(negedge div_8_clk);
        @(negedge div_8_clk);
        chk("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
